// File: rtl/sram_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_bist_ctrl
// Purpose  : March C- built-in self-test controller for a single-port SRAM
//            macro with a BIST port. On START it runs one full March C-
//            pass and then reports DONE and a sticky FAIL flag.
//              M0 up   : w0        M3 down : r0, w1
//              M1 up   : r0, w1    M4 down : r1, w0
//              M2 up   : r1, w0    M5 down : r0
//            "0" data is P_PATTERN and "1" data is ~P_PATTERN.
// Ports    : BIST_CLK, BIST_RESET_N   clock, async active-low reset
//            START                    single-cycle start request
//            BUSY / DONE / FAIL       test status to the SoC controller
//            A_BIST_EN/MEN/WEN/REN    macro BIST port controls (registered)
//            A_BIST_ADDR/DIN/BM       macro address, write data, bit mask
//            A_DOUT                   macro read data, valid one cycle
//                                     after a read is issued
//            FAIL_ADDR/DOUT/ELEM      first-mismatch log (optional)
// Options  : define BIST_FAILLOG_EN to add the first-mismatch log outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sram_march_bist_ctrl #(
  parameter int                      P_DATA_WIDTH = 32,
  parameter int                      P_ADDR_WIDTH = 9,
  parameter logic [P_DATA_WIDTH-1:0] P_PATTERN    = '0
) (
  input  logic                    BIST_CLK,
  input  logic                    BIST_RESET_N,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
`ifdef BIST_FAILLOG_EN
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [P_DATA_WIDTH-1:0] FAIL_DOUT,
  output logic [2:0]              FAIL_ELEM,
`endif
  input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0]              c_LAST_ELEM = 3'd5;
  localparam logic [P_ADDR_WIDTH-1:0] c_ADDR_MAX  = {P_ADDR_WIDTH{1'b1}};
  localparam logic [P_ADDR_WIDTH-1:0] c_ADDR_ONE  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Element helpers: M0 and M5 have a single op, M1..M4 have two.
  function automatic logic elem_two_op(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    return (e >= 3'd3);
  endfunction

  // The first op of every two-op element is a read, as is the sole op of M5.
  function automatic logic op_is_read(input logic [2:0] e, input logic ph);
    return elem_two_op(e) ? ~ph : (e == 3'd5);
  endfunction

  // 1 when the op uses the inverted background.
  function automatic logic op_data_one(input logic [2:0] e, input logic ph);
    logic v;
    case (e)
      3'd1, 3'd3: v = ph;    // r0 then w1
      3'd2, 3'd4: v = ~ph;   // r1 then w0
      default:    v = 1'b0;  // M0 w0, M5 r0
    endcase
    return v;
  endfunction

  logic [2:0]              state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic                    phase_q, phase_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    drain_q, drain_d;
  logic                    armed_q;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic                    en_q, en_d;
  logic                    men_q, men_d;
  logic                    wen_q, wen_d;
  logic                    ren_q, ren_d;
  logic [P_DATA_WIDTH-1:0] din_q, din_d;
  logic [P_DATA_WIDTH-1:0] bm_q, bm_d;
  logic                    cmp_vld_q, cmp_vld_d;
  logic [P_DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
  logic [P_ADDR_WIDTH-1:0] last_addr;
  logic                    mismatch;
  logic                    rd_next;
`ifdef BIST_FAILLOG_EN
  logic [P_ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]              cmp_elem_q, cmp_elem_d;
  logic [P_ADDR_WIDTH-1:0] flog_addr_q, flog_addr_d;
  logic [P_DATA_WIDTH-1:0] flog_dout_q, flog_dout_d;
  logic [2:0]              flog_elem_q, flog_elem_d;
`endif

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    busy_d    = busy_q;
    done_d    = done_q;
    fail_d    = fail_q;
    last_addr = elem_down(elem_q) ? '0 : c_ADDR_MAX;
    mismatch  = cmp_vld_q && (A_DOUT != cmp_exp_q);
`ifdef BIST_FAILLOG_EN
    flog_addr_d = flog_addr_q;
    flog_dout_d = flog_dout_q;
    flog_elem_d = flog_elem_q;
`endif

    case (state_q)
      S_IDLE: begin
        // armed_q blocks a START seen on the first edge after reset release.
        if (START && armed_q) begin
          state_d = S_SETUP;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          addr_d  = '0;
`ifdef BIST_FAILLOG_EN
          flog_addr_d = '0;
          flog_dout_d = '0;
          flog_elem_d = '0;
`endif
        end
      end
      S_SETUP: begin
        state_d = S_RUN;
        elem_d  = 3'd0;
        phase_d = 1'b0;
        addr_d  = '0;
      end
      S_RUN: begin
        if (elem_two_op(elem_q) && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == last_addr) begin
            // Element boundary: the address is reloaded, never wrapped.
            if (elem_q == c_LAST_ELEM) begin
              state_d = S_DRAIN;
              drain_d = 1'b0;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = elem_down(elem_q + 3'd1) ? c_ADDR_MAX : '0;
            end
          end else begin
            addr_d = elem_down(elem_q) ? (addr_q - c_ADDR_ONE) : (addr_q + c_ADDR_ONE);
          end
        end
      end
      S_DRAIN: begin
        // Two cycles so the final read has been compared before DONE.
        if (drain_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (mismatch) begin
      fail_d = 1'b1;
`ifdef BIST_FAILLOG_EN
      if (!fail_q) begin
        flog_addr_d = cmp_addr_q;
        flog_dout_d = A_DOUT;
        flog_elem_d = cmp_elem_q;
      end
`endif
    end

    // Port outputs are computed from the next state so that, once
    // registered, they line up with state_q/elem_q/phase_q/addr_q.
    en_d    = (state_d == S_SETUP) || (state_d == S_RUN) || (state_d == S_DRAIN);
    men_d   = (state_d == S_RUN);
    rd_next = op_is_read(elem_d, phase_d);
    ren_d   = men_d && rd_next;
    wen_d   = men_d && !rd_next;
    din_d   = !wen_d ? '0 : (op_data_one(elem_d, phase_d) ? ~P_PATTERN : P_PATTERN);
    bm_d    = {P_DATA_WIDTH{en_d}};

    // Compare stage sits one cycle behind the issued read.
    cmp_vld_d = ren_q;
    cmp_exp_d = op_data_one(elem_q, phase_q) ? ~P_PATTERN : P_PATTERN;
`ifdef BIST_FAILLOG_EN
    cmp_addr_d = addr_q;
    cmp_elem_d = elem_q;
`endif
  end

  always_ff @(posedge BIST_CLK or negedge BIST_RESET_N) begin
    if (!BIST_RESET_N) begin
      state_q   <= S_IDLE;
      elem_q    <= '0;
      phase_q   <= 1'b0;
      addr_q    <= '0;
      drain_q   <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      en_q      <= 1'b0;
      men_q     <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      din_q     <= '0;
      bm_q      <= '0;
      cmp_vld_q <= 1'b0;
      cmp_exp_q <= '0;
`ifdef BIST_FAILLOG_EN
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      flog_addr_q <= '0;
      flog_dout_q <= '0;
      flog_elem_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      armed_q   <= 1'b1;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      en_q      <= en_d;
      men_q     <= men_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      din_q     <= din_d;
      bm_q      <= bm_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_exp_q <= cmp_exp_d;
`ifdef BIST_FAILLOG_EN
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      flog_addr_q <= flog_addr_d;
      flog_dout_q <= flog_dout_d;
      flog_elem_q <= flog_elem_d;
`endif
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign FAIL        = fail_q;
  assign A_BIST_EN   = en_q;
  assign A_BIST_MEN  = men_q;
  assign A_BIST_WEN  = wen_q;
  assign A_BIST_REN  = ren_q;
  assign A_BIST_ADDR = addr_q;
  assign A_BIST_DIN  = din_q;
  assign A_BIST_BM   = bm_q;
`ifdef BIST_FAILLOG_EN
  assign FAIL_ADDR   = flog_addr_q;
  assign FAIL_DOUT   = flog_dout_q;
  assign FAIL_ELEM   = flog_elem_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_march_bist_ctrl
// Purpose  : Self-checking bench for sram_march_bist_ctrl. Two controllers
//            (background 0 and 0x55555555) each drive a behavioural 32x512
//            macro with optional stuck-at or coupling faults. A reference
//            model walks March C- over its own memory copy to predict the
//            access trace, FAIL and the first-mismatch log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_march_bist_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int N  = 1 << AW;
  localparam int TW = 2 + AW + DW;
  localparam logic [DW-1:0] PAT0 = 32'h0000_0000;
  localparam logic [DW-1:0] PAT1 = 32'h5555_5555;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    start = 2'b00;
  logic [1:0]    busy, done, fail, en, men, wen, ren;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] din  [2];
  logic [DW-1:0] bm   [2];
  logic [DW-1:0] dout [2];
`ifdef BIST_FAILLOG_EN
  logic [AW-1:0] fa [2];
  logic [DW-1:0] fd [2];
  logic [2:0]    fe [2];
`endif

  always #5 clk = ~clk;

  sram_march_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_PATTERN(PAT0)) u_dut0 (
    .BIST_CLK(clk), .BIST_RESET_N(rst_n), .START(start[0]),
    .BUSY(busy[0]), .DONE(done[0]), .FAIL(fail[0]),
    .A_BIST_EN(en[0]), .A_BIST_MEN(men[0]), .A_BIST_WEN(wen[0]), .A_BIST_REN(ren[0]),
    .A_BIST_ADDR(addr[0]), .A_BIST_DIN(din[0]), .A_BIST_BM(bm[0]),
`ifdef BIST_FAILLOG_EN
    .FAIL_ADDR(fa[0]), .FAIL_DOUT(fd[0]), .FAIL_ELEM(fe[0]),
`endif
    .A_DOUT(dout[0])
  );

  sram_march_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_PATTERN(PAT1)) u_dut1 (
    .BIST_CLK(clk), .BIST_RESET_N(rst_n), .START(start[1]),
    .BUSY(busy[1]), .DONE(done[1]), .FAIL(fail[1]),
    .A_BIST_EN(en[1]), .A_BIST_MEN(men[1]), .A_BIST_WEN(wen[1]), .A_BIST_REN(ren[1]),
    .A_BIST_ADDR(addr[1]), .A_BIST_DIN(din[1]), .A_BIST_BM(bm[1]),
`ifdef BIST_FAILLOG_EN
    .FAIL_ADDR(fa[1]), .FAIL_DOUT(fd[1]), .FAIL_ELEM(fe[1]),
`endif
    .A_DOUT(dout[1])
  );

  // Fault description per macro: 0 none, 1 stuck-at, 2 coupling
  // (a 0->1 transition of bit fbit at faddr sets bit fbit of word fvict).
  int ftype [2];
  int faddr [2];
  int fbit  [2];
  int fval  [2];
  int fvict [2];

  logic [DW-1:0] mem  [2][N];
  logic [DW-1:0] rmem [2][N];
  logic [TW-1:0] trace [2][10*N];
  logic          exp_fail  [2];
  int            exp_faddr [2];
  logic [DW-1:0] exp_fdout [2];
  int            exp_felem [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return (i == 0) ? PAT0 : PAT1;
  endfunction

  function automatic logic [DW-1:0] rd_fault(input int i, input int a, input logic [DW-1:0] raw);
    logic [DW-1:0] v;
    v = raw;
    if (ftype[i] == 1 && a == faddr[i]) v[fbit[i]] = (fval[i] != 0);
    return v;
  endfunction

  // Behavioural macro: write on the edge, read data appears after the edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en[i] && men[i] && wen[i]) begin
        mem[i][addr[i]] <= (din[i] & bm[i]) | (mem[i][addr[i]] & ~bm[i]);
        if (ftype[i] == 2 && int'(addr[i]) == faddr[i] && !mem[i][addr[i]][fbit[i]]
            && din[i][fbit[i]] && bm[i][fbit[i]])
          mem[i][fvict[i]][fbit[i]] <= 1'b1;
      end
      if (en[i] && men[i] && ren[i])
        dout[i] <= rd_fault(i, int'(addr[i]), mem[i][addr[i]]);
    end
  end

  // Reference: March C- as a table of elements, walked with plain loops.
  // Op codes: 0 w0, 1 w1, 2 r0, 3 r1.
  task automatic build_ref(input int i);
    int ops [6][2];
    int nops [6];
    int n, a, op;
    logic [DW-1:0] p, val, got;
    ops  = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
    nops = '{1, 2, 2, 2, 2, 1};
    p = pat(i);
    n = 0;
    exp_fail[i] = 1'b0; exp_faddr[i] = 0; exp_fdout[i] = '0; exp_felem[i] = 0;
    for (int w = 0; w < N; w++) rmem[i][w] = mem[i][w];
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < N; s++) begin
        a = (e >= 3) ? (N - 1 - s) : s;
        for (int k = 0; k < nops[e]; k++) begin
          op  = ops[e][k];
          val = (op == 1 || op == 3) ? ~p : p;
          if (op < 2) begin
            if (ftype[i] == 2 && a == faddr[i] && !rmem[i][a][fbit[i]] && val[fbit[i]])
              rmem[i][fvict[i]][fbit[i]] = 1'b1;
            rmem[i][a] = val;
            trace[i][n] = {1'b1, 1'b0, AW'(a), val};
          end else begin
            got = rd_fault(i, a, rmem[i][a]);
            if (got != val && !exp_fail[i]) begin
              exp_fail[i]  = 1'b1;
              exp_faddr[i] = a;
              exp_fdout[i] = got;
              exp_felem[i] = e;
            end
            trace[i][n] = {1'b0, 1'b1, AW'(a), {DW{1'b0}}};
          end
          n++;
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_d%0d", tag, i),
               {busy[i], done[i], fail[i], en[i], men[i], wen[i], ren[i], addr[i], din[i], bm[i]}, '0);
`ifdef BIST_FAILLOG_EN
      check_eq($sformatf("%s_log_d%0d", tag, i), {fa[i], fd[i], fe[i]}, '0);
`endif
    end
  endtask

  task automatic run_test(input string tag, input bit mid_start);
    int busy_cnt [2];
    int men_cnt  [2];
    int idx      [2];
    int terr     [2];
    logic [TW-1:0] first_acc [2];
    logic [TW-1:0] m3_a [2];
    logic [TW-1:0] m3_b [2];
    logic [TW-1:0] obs;
    bit fin;
    int c;
    for (int i = 0; i < 2; i++) begin
      build_ref(i);
      busy_cnt[i] = 0; men_cnt[i] = 0; idx[i] = 0; terr[i] = 0;
      first_acc[i] = '0; m3_a[i] = '0; m3_b[i] = '0;
    end
    @(negedge clk) start = 2'b11;
    @(negedge clk) start = 2'b00;
    fin = 1'b0;
    c = 0;
    while (!fin && c < 6000) begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) busy_cnt[i]++;
        if (bm[i] != {DW{en[i]}}) terr[i]++;
        if (men[i]) begin
          men_cnt[i]++;
          if (idx[i] < 10*N) begin
            obs = {wen[i], ren[i], addr[i], din[i]};
            if (obs != trace[i][idx[i]]) terr[i]++;
            if (idx[i] == 0)       first_acc[i] = obs;
            if (idx[i] == 5*N)     m3_a[i] = obs;
            if (idx[i] == 5*N + 1) m3_b[i] = obs;
          end
          idx[i]++;
        end
      end
      fin = done[0] && done[1];
      if (!fin) begin
        start = (mid_start && c == 100) ? 2'b11 : 2'b00;
        @(negedge clk);
        c++;
      end
    end
    start = 2'b00;
    check_eq({tag, "_timeout"}, fin, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_busy_len_d%0d", tag, i), busy_cnt[i], 1 + 10*N + 2);
      check_eq($sformatf("%s_men_len_d%0d", tag, i), men_cnt[i], 10*N);
      check_eq($sformatf("%s_trace_errs_d%0d", tag, i), terr[i], 0);
      check_eq($sformatf("%s_first_acc_d%0d", tag, i), first_acc[i], {1'b1, 1'b0, {AW{1'b0}}, pat(i)});
      check_eq($sformatf("%s_m3_rd_d%0d", tag, i), m3_a[i], {1'b0, 1'b1, {AW{1'b1}}, {DW{1'b0}}});
      check_eq($sformatf("%s_m3_wr_d%0d", tag, i), m3_b[i], {1'b1, 1'b0, {AW{1'b1}}, ~pat(i)});
      check_eq($sformatf("%s_end_flags_d%0d", tag, i), {busy[i], done[i], en[i], men[i]}, 4'b0100);
      check_eq($sformatf("%s_fail_d%0d", tag, i), fail[i], exp_fail[i]);
`ifdef BIST_FAILLOG_EN
      check_eq($sformatf("%s_log_addr_d%0d", tag, i), fa[i], AW'(exp_faddr[i]));
      check_eq($sformatf("%s_log_dout_d%0d", tag, i), fd[i], exp_fdout[i]);
      check_eq($sformatf("%s_log_elem_d%0d", tag, i), fe[i], 3'(exp_felem[i]));
`endif
    end
    // DONE and FAIL must hold while idle.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("%s_hold_d%0d", tag, i), {done[i], fail[i], busy[i]}, {1'b1, exp_fail[i], 1'b0});
  endtask

  task automatic set_random_fault(input int i, input int kind);
    ftype[i] = kind;
    faddr[i] = $urandom_range(0, N-1);
    fbit[i]  = $urandom_range(0, DW-1);
    fval[i]  = $urandom_range(0, 1);
    fvict[i] = (faddr[i] + 1 + $urandom_range(0, N-2)) % N;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ftype[i] = 0; faddr[i] = 0; fbit[i] = 0; fval[i] = 0; fvict[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_test("clean", 1'b0);

    // Stuck-at-1 on bit 3 of word 0x0A5; coupling fault on the other macro.
    ftype[0] = 1; faddr[0] = 'h0A5; fbit[0] = 3; fval[0] = 1;
    ftype[1] = 2; faddr[1] = 'h010; fbit[1] = 2; fvict[1] = 'h120;
    run_test("faults", 1'b1);
    check_eq("stuck_fail_d0", fail[0], 1'b1);
    check_eq("coupling_fail_d1", fail[1], 1'b1);
`ifdef BIST_FAILLOG_EN
    check_eq("stuck_log_d0", {fa[0], fd[0], fe[0]}, {9'h0A5, 32'h0000_0008, 3'd1});
`endif

    set_random_fault(0, 1);
    set_random_fault(1, 1);
    run_test("rand_stuck", 1'b0);

    // Reset in the middle of M2, then a START coinciding with release.
    ftype[0] = 0; ftype[1] = 0;
    @(negedge clk) start = 2'b11;
    @(negedge clk) start = 2'b00;
    repeat (1 + 3*N + $urandom_range(0, 2*N-1)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 2'b11;
    @(negedge clk) start = 2'b00;
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("start_at_release_d%0d", i), {busy[i], en[i]}, 2'b00);
    repeat (2) @(negedge clk);
    run_test("after_rst", 1'b0);

    set_random_fault(0, 2);
    set_random_fault(1, 2);
    run_test("rand_coupling", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
